store_queue_param: RTL
======================

Name: store_queue_param

Overview:
- Parametrised store buffer that follows the LSU store stage.
- Holds translated stores in a speculative queue until the scoreboard commits them.
- Moves committed stores into a commit queue, which drains to the D$ through a request/grant handshake.
- Generalises the fixed-depth store buffer with configurable depths and data width, full address-overlap checking across both queues, and optional store merging.

Parameters:
- SPEC_DEPTH, 4, speculative-queue entries (power of 2, >=2)
- COMMIT_DEPTH, 8, commit-queue entries (power of 2, >=2)
- DATA_W, 64, store data width in bits (32 or 64); BE_W = DATA_W/8
- PLEN, 56, physical address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all speculative entries
- valid_i  in  1  new translated store
- ready_o  out  1  speculative queue can accept a store
- paddr_i  in  PLEN  store physical address
- data_i  in  DATA_W  aligned store data
- be_i  in  BE_W  byte enables
- commit_i  in  1  commit oldest speculative store
- commit_ready_o  out  1  commit queue has space
- page_offset_i  in  12  load page offset to check
- page_offset_matches_o  out  1  a pending store overlaps this offset
- no_st_pending_o  out  1  both queues empty
- spec_empty_o  out  1  speculative queue empty
- mem_req_o  out  1  D$ write request
- mem_gnt_i  in  1  D$ grant
- mem_addr_o  out  PLEN  write address
- mem_data_o  out  DATA_W  write data
- mem_be_o  out  BE_W  write byte enables

Behaviour:
- Reset values:
  - all pointers and counters 0; all entry valid bits 0.
  - ready_o=1, commit_ready_o=1, no_st_pending_o=1, spec_empty_o=1.
  - mem_req_o=0, mem_addr_o/data_o/be_o=0, page_offset_matches_o=0.
- Speculative queue:
  - circular FIFO.
  - ready_o = (spec_cnt != SPEC_DEPTH).
  - Push on valid_i && ready_o && !flush_i; the entry is visible the next cycle.
- Flush:
  - flush_i clears spec_cnt and the spec pointers at the clock edge.
  - A push in the same cycle is dropped.
  - A commit in the same cycle still moves the head entry; commit takes priority over flush for that one entry.
  - The commit queue is never flushed.
- Commit:
  - On commit_i && commit_ready_o the spec head moves to the commit tail.
  - commit_ready_o = (commit_cnt != COMMIT_DEPTH).
  - commit_ready_o does not credit a same-cycle grant; this is conservative.
  - commit_i with spec empty is illegal; the RTL asserts on it and ignores it.
- Simultaneous push and commit: spec_cnt is unchanged.
- Simultaneous commit and grant: commit_cnt is unchanged.
- D$ side:
  - mem_req_o = (commit_cnt != 0); addr, data and be are driven from the commit head.
  - mem_addr_o, mem_data_o and mem_be_o stay stable while mem_req_o && !mem_gnt_i.
  - On mem_gnt_i the head pops; with back-to-back grants, one store retires per cycle.
  - Latency: push in cycle N, commit in N+1 → mem_req_o high in N+2 at the earliest.
- Address check (combinational):
  - page_offset_matches_o = 1 if any valid spec or commit entry has paddr[11:3] == page_offset_i[11:3].
  - The incoming store (valid_i, ignoring flush_i) is included in the check.
- Status outputs:
  - no_st_pending_o = (spec_cnt==0 && commit_cnt==0).
  - spec_empty_o = (spec_cnt==0).
- Wrap-around: pointers are log2(DEPTH) bits wide and wrap naturally; full/empty are derived from the counters, not from pointer comparison.
- Reset mid-operation: all queues clear asynchronously and mem_req_o drops immediately; no pending store is preserved.

Optional Feature:
- Macro: STORE_QUEUE_MERGE_EN.
- Defined:
  - A push whose paddr[PLEN-1:3] equals the youngest speculative entry merges into that entry instead of allocating.
  - Merge requires that entry not to be committed in the same cycle.
  - For each set bit of be_i, the byte in data_i overwrites the stored byte; the stored be becomes old | new.
  - Merge is allowed even when the queue is full, so ready_o = !full || merge_hit.
- Undefined: every push allocates a new entry and merge logic is absent.

Test Plan:
- Reset, then push 0x8000_0010 data 0xAA be 0x01, commit, grant at once → mem_req_o high 2 cycles after push with addr 0x8000_0010, data 0xAA, be 0x01; no_st_pending_o=1 after the grant.
- Push 4 stores with commits held off (SPEC_DEPTH=4) → ready_o=0; 5th valid_i is not accepted; one commit → ready_o=1 next cycle.
- Push 3 stores, commit 1, flush_i → spec_empty_o=1; commit queue keeps 1 entry and drains with its original data.
- COMMIT_DEPTH=8 filled with mem_gnt_i=0 → commit_ready_o=0, mem_addr_o stable for 20 cycles; then assert grant every cycle → 8 stores retire in 8 cycles, in order.
- Store at paddr 0x1238 pending, page_offset_i=0x23C → match=1; page_offset_i=0x240 → match=0; valid_i with paddr 0x0240 → match=1.
- With STORE_QUEUE_MERGE_EN: push 0x100 be 0x0F data 0x11223344, then 0x104 be 0xF0 data 0x55667788_00000000 → single entry, be 0xFF, data 0x55667788_11223344.

Source files
------------

// File: rtl/store_queue_param_if.sv
// -----------------------------------------------------------------------------
// store_queue_param_if
// Bundles the store-input handshake and the D$ write request/grant bus of the
// store queue.
//   slave  modport : the store queue itself
//   master modport : the LSU store stage plus the D$ (the queue's environment)
// Signals:
//   valid/ready      : translated-store handshake (LSU -> queue)
//   paddr/data/be    : store physical address, aligned data, byte enables
//   mem_req/mem_gnt  : D$ write request (queue -> D$) and its grant
//   mem_addr/data/be : write payload, taken from the commit-queue head
// -----------------------------------------------------------------------------
interface store_queue_param_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned PLEN   = 56
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              valid;
    logic              ready;
    logic [PLEN-1:0]   paddr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;

    logic              mem_req;
    logic              mem_gnt;
    logic [PLEN-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [BE_W-1:0]   mem_be;

    modport slave (
        input  valid, paddr, data, be, mem_gnt,
        output ready, mem_req, mem_addr, mem_data, mem_be
    );

    modport master (
        output valid, paddr, data, be, mem_gnt,
        input  ready, mem_req, mem_addr, mem_data, mem_be
    );
endinterface

// File: rtl/store_queue_param.sv
// -----------------------------------------------------------------------------
// store_queue_param
// Store buffer behind the LSU store stage. Translated stores wait in a
// speculative FIFO until commit_i moves the oldest one into the commit FIFO,
// which drains to the D$ through the mem_req/mem_gnt handshake.
//
// Optional feature (macro STORE_QUEUE_MERGE_EN): a push whose doubleword
// address equals the youngest speculative entry merges its enabled bytes into
// that entry instead of allocating a new one.
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : drop every speculative entry
//   commit_i               : move the oldest speculative store to commit queue
//   commit_ready_o         : commit queue has a free slot
//   page_offset_i          : load page offset to check for overlap
//   page_offset_matches_o  : some pending/incoming store hits that doubleword
//   no_st_pending_o        : both queues empty
//   spec_empty_o           : speculative queue empty
//   st_if (slave)          : store-input handshake and D$ write bus
// -----------------------------------------------------------------------------
module store_queue_param #(
    parameter int unsigned SPEC_DEPTH   = 4,
    parameter int unsigned COMMIT_DEPTH = 8,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned PLEN         = 56
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               commit_i,
    output logic               commit_ready_o,
    input  logic [11:0]        page_offset_i,
    output logic               page_offset_matches_o,
    output logic               no_st_pending_o,
    output logic               spec_empty_o,
    store_queue_param_if.slave st_if
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned SP_W = $clog2(SPEC_DEPTH);
    localparam int unsigned CM_W = $clog2(COMMIT_DEPTH);
    localparam logic [SP_W:0] SPEC_FULL = (SP_W+1)'(SPEC_DEPTH);
    localparam logic [CM_W:0] CMT_FULL  = (CM_W+1)'(COMMIT_DEPTH);

    // Entry payload storage (no reset: validity is tracked separately)
    logic [PLEN-1:0]   spec_addr_q   [SPEC_DEPTH];
    logic [DATA_W-1:0] spec_data_q   [SPEC_DEPTH];
    logic [BE_W-1:0]   spec_be_q     [SPEC_DEPTH];
    logic [PLEN-1:0]   commit_addr_q [COMMIT_DEPTH];
    logic [DATA_W-1:0] commit_data_q [COMMIT_DEPTH];
    logic [BE_W-1:0]   commit_be_q   [COMMIT_DEPTH];

    logic [SPEC_DEPTH-1:0]   spec_vld_q, spec_vld_d;
    logic [COMMIT_DEPTH-1:0] commit_vld_q, commit_vld_d;
    logic [SP_W-1:0]         spec_head_q, spec_head_d, spec_tail_q, spec_tail_d;
    logic [CM_W-1:0]         commit_head_q, commit_head_d, commit_tail_q, commit_tail_d;
    logic [SP_W:0]           spec_cnt_q, spec_cnt_d;
    logic [CM_W:0]           commit_cnt_q, commit_cnt_d;

    logic            spec_full;
    logic            commit_fire;
    logic            push_fire;
    logic            alloc;
    logic            merge_hit;
    logic            mem_req;
    logic            mem_pop;
    logic [SP_W-1:0] spec_young;

    assign spec_full      = (spec_cnt_q == SPEC_FULL);
    // No credit for a same-cycle grant: a full commit queue blocks commit.
    assign commit_ready_o = (commit_cnt_q != CMT_FULL);
    assign commit_fire    = commit_i && commit_ready_o && (spec_cnt_q != '0);
    assign spec_young     = spec_tail_q - SP_W'(1);

`ifdef STORE_QUEUE_MERGE_EN
    logic              merge_fire;
    logic [DATA_W-1:0] merge_data;
    logic [BE_W-1:0]   merge_be;

    // The youngest entry must stay in place this cycle; it only leaves when
    // it is also the head (single entry) and is being committed.
    assign merge_hit = st_if.valid && (spec_cnt_q != '0)
                    && (spec_addr_q[spec_young][PLEN-1:3] == st_if.paddr[PLEN-1:3])
                    && !(commit_fire && (spec_cnt_q == (SP_W+1)'(1)));
    assign merge_fire = push_fire && merge_hit;
    assign merge_be   = spec_be_q[spec_young] | st_if.be;

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge_byte
        assign merge_data[8*gi +: 8] = st_if.be[gi] ? st_if.data[8*gi +: 8]
                                                    : spec_data_q[spec_young][8*gi +: 8];
    end
`else
    assign merge_hit = 1'b0;
`endif

    assign st_if.ready = !spec_full || merge_hit;
    assign push_fire   = st_if.valid && st_if.ready && !flush_i;
    assign alloc       = push_fire && !merge_hit;

    assign mem_req  = (commit_cnt_q != '0);
    assign mem_pop  = mem_req && st_if.mem_gnt;

    // Next-state for pointers, counters and valid bits
    always_comb begin
        spec_vld_d    = spec_vld_q;
        spec_head_d   = spec_head_q;
        spec_tail_d   = spec_tail_q;
        commit_vld_d  = commit_vld_q;
        commit_head_d = commit_head_q;
        commit_tail_d = commit_tail_q;

        if (alloc) begin
            spec_vld_d[spec_tail_q] = 1'b1;
            spec_tail_d             = spec_tail_q + SP_W'(1);
        end
        if (commit_fire) begin
            spec_vld_d[spec_head_q]     = 1'b0;
            spec_head_d                 = spec_head_q + SP_W'(1);
            commit_vld_d[commit_tail_q] = 1'b1;
            commit_tail_d               = commit_tail_q + CM_W'(1);
        end
        spec_cnt_d = spec_cnt_q + (SP_W+1)'(alloc) - (SP_W+1)'(commit_fire);
        // Flush wins over everything speculative; the committed head has
        // already been copied out above.
        if (flush_i) begin
            spec_vld_d  = '0;
            spec_head_d = '0;
            spec_tail_d = '0;
            spec_cnt_d  = '0;
        end

        if (mem_pop) begin
            commit_vld_d[commit_head_q] = 1'b0;
            commit_head_d               = commit_head_q + CM_W'(1);
        end
        commit_cnt_d = commit_cnt_q + (CM_W+1)'(commit_fire) - (CM_W+1)'(mem_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_vld_q    <= '0;
            spec_head_q   <= '0;
            spec_tail_q   <= '0;
            spec_cnt_q    <= '0;
            commit_vld_q  <= '0;
            commit_head_q <= '0;
            commit_tail_q <= '0;
            commit_cnt_q  <= '0;
        end else begin
            spec_vld_q    <= spec_vld_d;
            spec_head_q   <= spec_head_d;
            spec_tail_q   <= spec_tail_d;
            spec_cnt_q    <= spec_cnt_d;
            commit_vld_q  <= commit_vld_d;
            commit_head_q <= commit_head_d;
            commit_tail_q <= commit_tail_d;
            commit_cnt_q  <= commit_cnt_d;
        end
    end

    // Payload writes
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            spec_addr_q[spec_tail_q] <= st_if.paddr;
            spec_data_q[spec_tail_q] <= st_if.data;
            spec_be_q[spec_tail_q]   <= st_if.be;
        end
`ifdef STORE_QUEUE_MERGE_EN
        if (merge_fire) begin
            spec_data_q[spec_young] <= merge_data;
            spec_be_q[spec_young]   <= merge_be;
        end
`endif
        if (commit_fire) begin
            commit_addr_q[commit_tail_q] <= spec_addr_q[spec_head_q];
            commit_data_q[commit_tail_q] <= spec_data_q[spec_head_q];
            commit_be_q[commit_tail_q]   <= spec_be_q[spec_head_q];
        end
    end

    // D$ side: payload forced to zero while idle so outputs are clean
    assign st_if.mem_req  = mem_req;
    assign st_if.mem_addr = mem_req ? commit_addr_q[commit_head_q] : '0;
    assign st_if.mem_data = mem_req ? commit_data_q[commit_head_q] : '0;
    assign st_if.mem_be   = mem_req ? commit_be_q[commit_head_q]   : '0;

    // Doubleword-granular overlap check against both queues and the incoming store
    logic [SPEC_DEPTH-1:0]   spec_hit;
    logic [COMMIT_DEPTH-1:0] commit_hit;
    logic                    in_hit;
    logic                    unused_page_offset_lsb;

    for (genvar gi = 0; gi < SPEC_DEPTH; gi++) begin : g_spec_hit
        assign spec_hit[gi] = spec_vld_q[gi] && (spec_addr_q[gi][11:3] == page_offset_i[11:3]);
    end
    for (genvar gi = 0; gi < COMMIT_DEPTH; gi++) begin : g_commit_hit
        assign commit_hit[gi] = commit_vld_q[gi] && (commit_addr_q[gi][11:3] == page_offset_i[11:3]);
    end

    assign in_hit                 = st_if.valid && (st_if.paddr[11:3] == page_offset_i[11:3]);
    assign page_offset_matches_o  = (|spec_hit) || (|commit_hit) || in_hit;
    assign unused_page_offset_lsb = ^page_offset_i[2:0];

    assign no_st_pending_o = (spec_cnt_q == '0) && (commit_cnt_q == '0);
    assign spec_empty_o    = (spec_cnt_q == '0);

    // Committing from an empty speculative queue is an upstream protocol bug
    a_no_commit_when_empty: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(commit_i && (spec_cnt_q == '0)));

endmodule
